// File: rtl/stack_ctrl_pkg.sv
// Shared types and encodings for the multicycle stack-machine controller.
package stack_ctrl_pkg;

    typedef enum logic [3:0] {
        StIf,
        StDecode,
        StMemRd,
        StPushMem,
        StPopA,
        StLdA,
        StPopB,
        StLdB,
        StAlu,
        StAluNot,
        StPushRes,
        StMemWr,
        StJump,
        StBranch,
        StHalt,
        StTrap
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [2:0] XOP_HALT = 3'b000;
    localparam logic [2:0] XOP_NOP  = 3'b001;

    typedef enum logic [1:0] {
        TrapNone      = 2'd0,
        TrapOverflow  = 2'd1,
        TrapUnderflow = 2'd2,
        TrapIllegal   = 2'd3
    } trap_cause_e;

    typedef enum logic [1:0] {
        AluAdd = 2'd0,
        AluSub = 2'd1,
        AluAnd = 2'd2,
        AluNot = 2'd3
    } alu_op_e;

endpackage

// File: rtl/stack_ctrl_mc_if.sv
// Controller <-> datapath bundle: opcode and memory ready in, control strobes and status out.
interface stack_ctrl_mc_if #(
    parameter int unsigned OPW = 3,
    parameter int unsigned CW  = 5
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           IorD;
    logic           srcA;
    logic           srcB;
    logic           lda;
    logic           ldb;
    logic           PCsrc;
    logic           PCwrite;
    logic           memRead;
    logic           IRwrite;
    logic           tos;
    logic           pop;
    logic           push;
    logic           MtoS;
    logic           PCwriteCond;
    logic           memWrite;
    logic [1:0]     ALUop;
    logic [CW-1:0]  occupancy;
    logic           halted;
    logic           trap;
    logic [1:0]     trap_cause;

    // Controller side.
    modport master (
        input  opcode, mem_ready,
        output IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite, tos, pop, push,
               MtoS, PCwriteCond, memWrite, ALUop, occupancy, halted, trap, trap_cause
    );

    // Datapath side.
    modport slave (
        output opcode, mem_ready,
        input  IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite, tos, pop, push,
               MtoS, PCwriteCond, memWrite, ALUop, occupancy, halted, trap, trap_cause
    );
endinterface

// File: rtl/stack_occ_counter.sv
// Up/down stack occupancy counter with full and low-watermark flags.
module stack_occ_counter #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Cw    = $clog2(Depth + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [Cw-1:0] count_o,
    output logic          is_full_o,
    output logic          lt1_o,
    output logic          lt2_o
);

    logic [Cw-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        // Guards are belt-and-braces; the controller never pushes when full or pops when empty.
        if (push_i && !is_full_o) begin
            count_d = count_q + Cw'(1);
        end else if (pop_i && !lt1_o) begin
            count_d = count_q - Cw'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign is_full_o = (count_q == Cw'(Depth));
    assign lt1_o     = (count_q == '0);
    assign lt2_o     = (count_q < Cw'(2));

endmodule

// File: rtl/stack_ctrl_mc.sv
// Multicycle stack-machine controller with memory wait states and occupancy traps.
module stack_ctrl_mc
    import stack_ctrl_pkg::*;
#(
    parameter int unsigned OPW         = 3,
    parameter int unsigned STACK_DEPTH = 16,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    stack_ctrl_mc_if.master ctrl_if
);

    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

    state_e      state_q, state_d;
    trap_cause_e trap_cause_q, trap_cause_d;

    logic [2:0]    op_lo;
    logic          op_ext;
    logic          mem_go;
    logic          push_s, pop_s;
    logic          occ_full, occ_lt1, occ_lt2;
    logic [CW-1:0] occ_count;

    assign op_lo  = ctrl_if.opcode[2:0];
    assign op_ext = (ctrl_if.opcode >> 3) != '0;
    assign mem_go = MEM_WAIT_EN ? ctrl_if.mem_ready : 1'b1;

    stack_occ_counter #(
        .Depth (STACK_DEPTH),
        .Cw    (CW)
    ) u_occ (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .count_o   (occ_count),
        .is_full_o (occ_full),
        .lt1_o     (occ_lt1),
        .lt2_o     (occ_lt2)
    );

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        unique case (state_q)
            StIf:      if (mem_go) state_d = StDecode;
            StDecode: begin
                if (op_ext) begin
                    if (op_lo == XOP_HALT) begin
                        state_d = StHalt;
                    end else if (op_lo == XOP_NOP) begin
                        state_d = StIf;
                    end else begin
                        state_d      = StTrap;
                        trap_cause_d = TrapIllegal;
                    end
                end else begin
                    // Occupancy checks override the normal decode so the counter never wraps.
                    unique case (op_lo)
                        OP_PUSH: begin
                            if (occ_full) begin
                                state_d      = StTrap;
                                trap_cause_d = TrapOverflow;
                            end else begin
                                state_d = StMemRd;
                            end
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            if (occ_lt2) begin
                                state_d      = StTrap;
                                trap_cause_d = TrapUnderflow;
                            end else begin
                                state_d = StPopA;
                            end
                        end
                        OP_NOT, OP_POP, OP_JMP, OP_JZ: begin
                            if (occ_lt1) begin
                                state_d      = StTrap;
                                trap_cause_d = TrapUnderflow;
                            end else if (op_lo == OP_JMP) begin
                                state_d = StJump;
                            end else if (op_lo == OP_JZ) begin
                                state_d = StBranch;
                            end else begin
                                state_d = StPopA;
                            end
                        end
                        default: state_d = StIf;
                    endcase
                end
            end
            StMemRd:   if (mem_go) state_d = StPushMem;
            StPushMem: state_d = StIf;
            StPopA:    state_d = StLdA;
            StLdA: begin
                if (op_lo == OP_POP) begin
                    state_d = StMemWr;
                end else if (op_lo == OP_NOT) begin
                    state_d = StAluNot;
                end else begin
                    state_d = StPopB;
                end
            end
            StPopB:    state_d = StLdB;
            StLdB:     state_d = StAlu;
            StAlu:     state_d = StPushRes;
            StAluNot:  state_d = StPushRes;
            StPushRes: state_d = StIf;
            StMemWr:   if (mem_go) state_d = StIf;
            StJump:    state_d = StIf;
            StBranch:  state_d = StIf;
            StHalt:    state_d = StHalt;
            StTrap:    state_d = StTrap;
            default:   state_d = StIf;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIf;
            trap_cause_q <= TrapNone;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Strobes are Moore decodes of the state, forced low while reset is held.
    always_comb begin
        ctrl_if.IorD        = 1'b0;
        ctrl_if.srcA        = 1'b0;
        ctrl_if.srcB        = 1'b0;
        ctrl_if.lda         = 1'b0;
        ctrl_if.ldb         = 1'b0;
        ctrl_if.PCsrc       = 1'b0;
        ctrl_if.PCwrite     = 1'b0;
        ctrl_if.memRead     = 1'b0;
        ctrl_if.IRwrite     = 1'b0;
        ctrl_if.tos         = 1'b0;
        ctrl_if.MtoS        = 1'b0;
        ctrl_if.PCwriteCond = 1'b0;
        ctrl_if.memWrite    = 1'b0;
        ctrl_if.ALUop       = AluAdd;
        ctrl_if.halted      = 1'b0;
        ctrl_if.trap        = 1'b0;
        push_s              = 1'b0;
        pop_s               = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIf: begin
                    ctrl_if.memRead = 1'b1;
                    ctrl_if.PCwrite = mem_go;
                    ctrl_if.IRwrite = mem_go;
                end
                StDecode:  ctrl_if.tos = 1'b1;
                StMemRd: begin
                    ctrl_if.IorD    = 1'b1;
                    ctrl_if.memRead = 1'b1;
                end
                StPushMem: begin
                    ctrl_if.MtoS = 1'b1;
                    push_s       = 1'b1;
                end
                StPopA, StPopB: pop_s = 1'b1;
                StLdA:     ctrl_if.lda = 1'b1;
                StLdB:     ctrl_if.ldb = 1'b1;
                StMemWr: begin
                    ctrl_if.IorD     = 1'b1;
                    ctrl_if.memWrite = 1'b1;
                end
                StJump: begin
                    ctrl_if.PCsrc   = 1'b1;
                    ctrl_if.PCwrite = 1'b1;
                end
                StBranch: begin
                    ctrl_if.PCsrc       = 1'b1;
                    ctrl_if.PCwriteCond = 1'b1;
                end
                StAluNot:  ctrl_if.ALUop = AluNot;
                StAlu:     ctrl_if.ALUop = ctrl_if.opcode[1:0];
                StPushRes: push_s = 1'b1;
                StHalt:    ctrl_if.halted = 1'b1;
                StTrap:    ctrl_if.trap = 1'b1;
                default:   ;
            endcase
        end
    end

    assign ctrl_if.push       = push_s;
    assign ctrl_if.pop        = pop_s;
    assign ctrl_if.occupancy  = occ_count;
    assign ctrl_if.trap_cause = trap_cause_q;

endmodule

// File: tb/tb_stack_ctrl_mc.sv
// Scoreboard bench for stack_ctrl_mc (OPW=4, STACK_DEPTH=4, MEM_WAIT_EN=1).
module tb_stack_ctrl_mc;

    localparam int unsigned OPW   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_NOT  = 4'b0011;
    localparam logic [3:0] C_PUSH = 4'b0100;
    localparam logic [3:0] C_POP  = 4'b0101;
    localparam logic [3:0] C_JMP  = 4'b0110;
    localparam logic [3:0] C_JZ   = 4'b0111;
    localparam logic [3:0] C_HALT = 4'b1000;
    localparam logic [3:0] C_NOP  = 4'b1001;
    localparam logic [3:0] C_ILL  = 4'b1010;

    typedef enum {
        E_RST, E_IF, E_DEC, E_MRD, E_PMEM, E_POPA, E_LDA, E_POPB, E_LDB,
        E_ALU, E_ANOT, E_PRES, E_MWR, E_JMP, E_BR, E_HALT, E_TRAP
    } tst_e;

    typedef struct {
        tst_e        s;
        int          idx;
        logic [23:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sbq[$];
    exp_t m_e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_step = 0;

    stack_ctrl_mc_if #(.OPW(OPW), .CW(CW)) bus ();

    stack_ctrl_mc #(
        .OPW         (OPW),
        .STACK_DEPTH (DEPTH),
        .MEM_WAIT_EN (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    always #5 clk = ~clk;

    wire [23:0] act = {bus.IorD, bus.srcA, bus.srcB, bus.lda, bus.ldb, bus.PCsrc, bus.PCwrite,
                       bus.memRead, bus.IRwrite, bus.tos, bus.pop, bus.push, bus.MtoS,
                       bus.PCwriteCond, bus.memWrite, bus.ALUop, bus.halted, bus.trap,
                       bus.trap_cause, bus.occupancy};

    // Strobe bits: 14 IorD,13 srcA,12 srcB,11 lda,10 ldb,9 PCsrc,8 PCwrite,7 memRead,
    // 6 IRwrite,5 tos,4 pop,3 push,2 MtoS,1 PCwriteCond,0 memWrite.
    function automatic logic [23:0] ev(tst_e s, bit rdy, int occ, int tc, int alu);
        logic [14:0] st;
        logic [1:0]  a;
        logic        h;
        logic        t;
        logic [1:0]  tcv;
        logic [2:0]  ov;
        st  = '0;
        a   = 2'd0;
        h   = 1'b0;
        t   = 1'b0;
        tcv = tc[1:0];
        ov  = occ[2:0];
        case (s)
            E_IF:   begin st[7] = 1'b1; st[8] = rdy; st[6] = rdy; end
            E_DEC:  st[5] = 1'b1;
            E_MRD:  begin st[14] = 1'b1; st[7] = 1'b1; end
            E_PMEM: begin st[2] = 1'b1; st[3] = 1'b1; end
            E_POPA, E_POPB: st[4] = 1'b1;
            E_LDA:  st[11] = 1'b1;
            E_LDB:  st[10] = 1'b1;
            E_MWR:  begin st[14] = 1'b1; st[0] = 1'b1; end
            E_JMP:  begin st[9] = 1'b1; st[8] = 1'b1; end
            E_BR:   begin st[9] = 1'b1; st[1] = 1'b1; end
            E_ANOT: a = 2'd3;
            E_ALU:  a = alu[1:0];
            E_PRES: st[3] = 1'b1;
            E_HALT: h = 1'b1;
            E_TRAP: t = 1'b1;
            default: ;
        endcase
        return {st, a, h, t, tcv, ov};
    endfunction

    task automatic step(input tst_e s, input logic [3:0] op, input bit rdy, input int occ,
                        input int tc = 0, input int alu = 0);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        e.s   = s;
        e.idx = n_step;
        e.v   = ev(s, rdy, occ, tc, alu);
        n_step++;
        sbq.push_back(e);
    endtask

    task automatic rst_cyc();
        exp_t e;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        e.s   = E_RST;
        e.idx = n_step;
        e.v   = ev(E_RST, 1'b0, 0, 0, 0);
        n_step++;
        sbq.push_back(e);
    endtask

    task automatic push_ins(input int occ);
        step(E_IF,   C_PUSH, 1'b1, occ);
        step(E_DEC,  C_PUSH, 1'b1, occ);
        step(E_MRD,  C_PUSH, 1'b1, occ);
        step(E_PMEM, C_PUSH, 1'b1, occ);
    endtask

    // Monitor: compares every cycle the stimulus has queued an expectation for.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            m_e = sbq.pop_front();
            n_cmp++;
            if (act !== m_e.v) begin
                n_bad++;
                $display("FAIL step%0d %s: got %h want %h", m_e.idx, m_e.s.name(), act, m_e.v);
            end
        end
    end

    initial begin
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        rst_cyc();
        rst_cyc();

        // PUSH with three wait cycles in IF and in MEM_RD: 10 cycles.
        repeat (3) step(E_IF, C_PUSH, 1'b0, 0);
        step(E_IF, C_PUSH, 1'b1, 0);
        step(E_DEC, C_PUSH, 1'b1, 0);
        repeat (3) step(E_MRD, C_PUSH, 1'b0, 0);
        step(E_MRD, C_PUSH, 1'b1, 0);
        step(E_PMEM, C_PUSH, 1'b1, 0);

        // Second PUSH, mem_ready low in DECODE must not matter.
        step(E_IF,   C_PUSH, 1'b1, 1);
        step(E_DEC,  C_PUSH, 1'b0, 1);
        step(E_MRD,  C_PUSH, 1'b1, 1);
        step(E_PMEM, C_PUSH, 1'b1, 1);

        // SUB at occupancy 2: 8 cycles, leaves 1.
        step(E_IF,   C_SUB, 1'b1, 2);
        step(E_DEC,  C_SUB, 1'b1, 2);
        step(E_POPA, C_SUB, 1'b1, 2);
        step(E_LDA,  C_SUB, 1'b1, 1);
        step(E_POPB, C_SUB, 1'b1, 1);
        step(E_LDB,  C_SUB, 1'b1, 0);
        step(E_ALU,  C_SUB, 1'b1, 0, 0, 1);
        step(E_PRES, C_SUB, 1'b1, 0);

        // NOT: 6 cycles, net 0.
        step(E_IF,   C_NOT, 1'b1, 1);
        step(E_DEC,  C_NOT, 1'b1, 1);
        step(E_POPA, C_NOT, 1'b1, 1);
        step(E_LDA,  C_NOT, 1'b1, 0);
        step(E_ANOT, C_NOT, 1'b1, 0);
        step(E_PRES, C_NOT, 1'b1, 0);

        step(E_IF,  C_JMP, 1'b1, 1);
        step(E_DEC, C_JMP, 1'b1, 1);
        step(E_JMP, C_JMP, 1'b1, 1);
        step(E_IF,  C_JZ,  1'b1, 1);
        step(E_DEC, C_JZ,  1'b1, 1);
        step(E_BR,  C_JZ,  1'b1, 1);
        step(E_IF,  C_NOP, 1'b1, 1);
        step(E_DEC, C_NOP, 1'b1, 1);

        // POP with one MEM_WR wait cycle.
        step(E_IF,   C_POP, 1'b1, 1);
        step(E_DEC,  C_POP, 1'b1, 1);
        step(E_POPA, C_POP, 1'b1, 1);
        step(E_LDA,  C_POP, 1'b1, 0);
        step(E_MWR,  C_POP, 1'b0, 0);
        step(E_MWR,  C_POP, 1'b1, 0);

        // ADD at occupancy 1 -> underflow trap, sticky.
        push_ins(0);
        step(E_IF,  C_ADD, 1'b1, 1);
        step(E_DEC, C_ADD, 1'b1, 1);
        repeat (20) step(E_TRAP, C_ADD, 1'b1, 1, 2);
        rst_cyc();

        // Fifth PUSH at full depth -> overflow trap.
        for (int i = 0; i < 4; i++) push_ins(i);
        step(E_IF,  C_PUSH, 1'b1, 4);
        step(E_DEC, C_PUSH, 1'b1, 4);
        repeat (3) step(E_TRAP, C_PUSH, 1'b1, 4, 1);
        rst_cyc();

        step(E_IF,  C_ILL, 1'b1, 0);
        step(E_DEC, C_ILL, 1'b1, 0);
        repeat (2) step(E_TRAP, C_ILL, 1'b1, 0, 3);
        rst_cyc();

        // Unary underflow: POP on an empty stack.
        step(E_IF,  C_POP, 1'b1, 0);
        step(E_DEC, C_POP, 1'b1, 0);
        repeat (2) step(E_TRAP, C_POP, 1'b1, 0, 2);
        rst_cyc();

        step(E_IF,  C_HALT, 1'b1, 0);
        step(E_DEC, C_HALT, 1'b1, 0);
        repeat (5) step(E_HALT, C_HALT, 1'b1, 0);
        rst_cyc();

        // Reset asserted during a MEM_WR stall.
        push_ins(0);
        step(E_IF,   C_POP, 1'b1, 1);
        step(E_DEC,  C_POP, 1'b1, 1);
        step(E_POPA, C_POP, 1'b1, 1);
        step(E_LDA,  C_POP, 1'b1, 0);
        repeat (2) step(E_MWR, C_POP, 1'b0, 0);
        rst_cyc();
        step(E_IF,  C_PUSH, 1'b1, 0);
        step(E_DEC, C_PUSH, 1'b1, 0);

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_ctrl_mc.md
Name: stack_ctrl_mc

Overview:
Parametrised multicycle controller for the stack-machine datapath, the successor of the current fixed 3-bit controller. It adds memory wait-state handshaking and stack-occupancy tracking with overflow/underflow traps. With OPW>3 it also decodes extended opcodes (HALT, NOP). It sits beside the datapath, drives its Moore-style control strobes, and receives the IR opcode field plus memory ready.

Parameters:
OPW, 3, opcode width; must be >=3; bits [OPW-1:3] select the extended opcode space.
STACK_DEPTH, 16, stack entries tracked for overflow/underflow checks; >=2.
MEM_WAIT_EN, 1, 1 = IF/MEM_RD/MEM_WR stall until mem_ready; 0 = single-cycle memory, mem_ready ignored.
CW, $clog2(STACK_DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
opcode  in  OPW  IR opcode field; stable from the cycle after IF completes
mem_ready  in  1  memory access completes this cycle
IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite, tos, pop, push, MtoS, PCwriteCond, memWrite  out  1 each  datapath strobes, same meaning as the existing controller
ALUop  out  2  0=ADD, 1=SUB, 2=AND, 3=NOT
occupancy  out  CW  current stack entry count
halted  out  1  controller in HALT
trap  out  1  controller in TRAP
trap_cause  out  2  0=none, 1=overflow, 2=underflow, 3=illegal opcode

Behaviour:
- Reset (async): state=IF, occupancy=0, trap_cause=0. While rst=1 every output is 0; the IF strobes appear in the first cycle after rst deasserts.
- Base opcodes (upper bits 0): 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- Extended opcodes (OPW>3, upper bits nonzero): low 000 = HALT, low 001 = NOP, anything else = illegal.
- States and transitions:
  - IF -> DECODE.
  - DECODE: PUSH -> MEM_RD; JMP -> JUMP; JZ -> BRANCH; HALT -> HALT; NOP -> IF; illegal -> TRAP(3); all other opcodes -> POP_A.
  - MEM_RD -> PUSH_MEM -> IF.
  - POP_A -> LD_A. LD_A: POP -> MEM_WR; NOT -> ALU_NOT; otherwise -> POP_B.
  - POP_B -> LD_B -> ALU -> PUSH_RES -> IF. ALU_NOT -> PUSH_RES.
  - MEM_WR, JUMP, BRANCH -> IF.
  - HALT and TRAP are sticky until rst.
- Occupancy checks, evaluated in DECODE and taking priority over the normal transition:
  - PUSH with occupancy==STACK_DEPTH -> TRAP(1).
  - ADD/SUB/AND with occupancy<2 -> TRAP(2).
  - NOT/POP/JMP/JZ with occupancy<1 -> TRAP(2).
  - The check guarantees the counter never wraps.
- Outputs per state (all others 0):
  - IF: memRead=1, IorD=0, srcA=0, srcB=0, ALUop=0, PCsrc=0; PCwrite and IRwrite = mem_ready (forced 1 when MEM_WAIT_EN=0).
  - DECODE: tos=1.
  - MEM_RD: IorD=1, memRead=1.
  - PUSH_MEM: MtoS=1, push=1.
  - POP_A, POP_B: pop=1.
  - LD_A: lda=1. LD_B: ldb=1.
  - MEM_WR: IorD=1, memWrite=1 (held through the stall).
  - JUMP: PCsrc=1, PCwrite=1.
  - BRANCH: PCsrc=1, PCwriteCond=1.
  - ALU_NOT: ALUop=3. ALU: ALUop=opcode[1:0].
  - PUSH_RES: push=1.
  - HALT: halted=1. TRAP: trap=1.
- Wait states: with MEM_WAIT_EN=1, IF/MEM_RD/MEM_WR advance only in a cycle where mem_ready=1; otherwise they hold with memRead/memWrite asserted. mem_ready is ignored in every other state.
- Occupancy counter: +1 on each push strobe, -1 on each pop strobe; push and pop never assert in the same cycle. Net effect per instruction: PUSH +1, POP -1, binary ALU -1, NOT 0, JMP/JZ/NOP 0.
- Latency with no stalls, in cycles: ADD/SUB/AND 8, NOT 6, PUSH 4, POP 5, JMP/JZ 3, NOP 2.
- Reset mid-instruction (including mid-stall) returns to IF, clears occupancy and trap_cause, and outputs go to 0 immediately.

Decomposition:
- Package stack_ctrl_pkg holds:
  - the state enum;
  - base opcode localparams (OP_ADD..OP_JZ) and extended low codes (XOP_HALT, XOP_NOP);
  - the trap_cause encoding;
  - the ALUop encoding.
- One sub-module, stack_occ_counter: parametrised up/down counter taking push/pop, with outputs count, is_full, lt1, lt2. The FSM and output decode stay in stack_ctrl_mc.

Test Plan:
- MEM_WAIT_EN=1: PUSH with mem_ready low for 3 cycles in both IF and MEM_RD -> memRead held; PCwrite/IRwrite pulse only on the ready cycle; occupancy 0->1; 10 cycles total.
- Two PUSHes then SUB (opcode 001) -> pop asserted in POP_A and POP_B; ALUop=1 in ALU; push in PUSH_RES; occupancy 2->1; SUB takes 8 cycles.
- ADD at occupancy 1 -> TRAP after DECODE with trap_cause=2, no pop strobe; stays in TRAP over 20 cycles; rst returns to IF with occupancy 0.
- STACK_DEPTH=4: five PUSHes -> the fifth traps with trap_cause=1; occupancy stays 4.
- OPW=4: opcode 4'b1001 -> NOP, back to IF in 2 cycles; 4'b1000 -> halted=1 sticky; 4'b1010 -> trap_cause=3.
- Assert rst mid-stall in MEM_WR -> memWrite drops immediately; after release, IF strobes appear and occupancy=0.
